// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg: state codes, access sizes and alignment helper
package mem_access_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return size == SIZE_B ? 1'b0 : size == SIZE_H ? off[0] : |off;
   endfunction
endpackage

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: single-port memory bus between the sequencer and the memory
interface mem_access_sequencer_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ack);
   modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_sequencer_mem_lane_align.sv
// mem_access_sequencer_mem_lane_align: byte enables, store lane replication and load extraction
module mem_access_sequencer_mem_lane_align
   import mem_access_sequencer_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);
   logic [15:0] sh;
   always_comb begin
      sh = 16'(rdata >> {off, 3'b000});
      be = size == SIZE_B ? 4'b0001 << off : size == SIZE_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_rep = size == SIZE_B ? {4{wdata[7:0]}} : size == SIZE_H ? {2{wdata[15:0]}} : wdata;
      rdata_ext = size == SIZE_B ? {{24{sh[7] & ~uns}}, sh[7:0]} :
                  size == SIZE_H ? {{16{sh[15] & ~uns}}, sh[15:0]} : rdata;
   end
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: shares one single-port memory between load/store and fetch,
// serving data first and stalling the pipeline until both accesses are finished.
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        stall,
   output logic [1:0]  err,
   mem_access_sequencer_if.master mem
);
   state_t      state;
   logic        pend_fetch, svc_data, uns_r;
   logic [31:0] fetch_addr;
   logic [1:0]  off_r, size_r, size_n, al_off, al_size;
   logic [7:0]  cnt;
   logic        d_req, mis, ack, tmo, fin;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;
   always_comb begin
      d_req = d_read | d_write;
      size_n = d_size == 2'b11 ? SIZE_W : d_size;
      mis = d_req & misaligned(size_n, d_addr[1:0]);
      al_off = state == IDLE ? d_addr[1:0] : off_r;
      al_size = state == IDLE ? size_n : size_r;
      ack = mem.mem_req & mem.mem_ack;
      tmo = mem.mem_req & ~mem.mem_ack & (cnt == 8'(TIMEOUT_CYC - 1));
      fin = ack | tmo;
      stall = ((state == IDLE) & (d_req | if_req)) | (state == DATA) | (state == FETCH);
   end
   mem_access_sequencer_mem_lane_align u_align (
      .off(al_off), .size(al_size), .uns(uns_r), .wdata(d_wdata), .rdata(mem.mem_rdata),
      .be(al_be), .wdata_rep(al_wdata), .rdata_ext(al_rdata)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pend_fetch <= 1'b0;
         svc_data <= 1'b0;
         uns_r <= 1'b0;
         fetch_addr <= '0;
         off_r <= '0;
         size_r <= SIZE_B;
         cnt <= '0;
         if_rdata <= NOP_INST;
         if_valid <= 1'b0;
         d_rdata <= '0;
         d_done <= 1'b0;
         err <= '0;
         mem.mem_req <= 1'b0;
         mem.mem_we <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_wdata <= '0;
         mem.mem_be <= '0;
      end else begin
         if_valid <= 1'b0;
         d_done <= 1'b0;
         case (state)
            IDLE: begin
               pend_fetch <= if_req;
               svc_data <= d_req;
               fetch_addr <= if_addr & ~32'h3;
               off_r <= d_addr[1:0];
               size_r <= size_n;
               uns_r <= d_unsigned;
               err <= {1'b0, mis};
               if (mis) d_rdata <= '0;
               if (d_req & ~mis) begin
                  state <= DATA;
                  mem.mem_req <= 1'b1;
                  mem.mem_we <= d_write;
                  mem.mem_addr <= d_addr & ~32'h3;
                  mem.mem_be <= al_be;
                  mem.mem_wdata <= al_wdata;
               end else if (if_req) begin
                  state <= FETCH;
                  mem.mem_req <= 1'b1;
                  mem.mem_we <= 1'b0;
                  mem.mem_addr <= if_addr & ~32'h3;
                  mem.mem_be <= 4'hf;
               end else if (mis) begin
                  state <= DONE;
                  d_done <= 1'b1;
               end
            end
            DATA: begin
               if (fin) begin
                  mem.mem_req <= 1'b0;
                  cnt <= '0;
                  err[1] <= err[1] | tmo;
                  if (!mem.mem_we) d_rdata <= tmo ? '0 : al_rdata;
                  if (pend_fetch) begin
                     state <= FETCH;
                     mem.mem_we <= 1'b0;
                     mem.mem_addr <= fetch_addr;
                     mem.mem_be <= 4'hf;
                  end else begin
                     state <= DONE;
                     d_done <= 1'b1;
                  end
               end else cnt <= cnt + 8'd1;
            end
            FETCH: begin
               // after a data access the request is re-raised one cycle later
               if (fin) begin
                  mem.mem_req <= 1'b0;
                  cnt <= '0;
                  err[1] <= err[1] | tmo;
                  if_rdata <= tmo ? NOP_INST : mem.mem_rdata;
                  state <= DONE;
                  if_valid <= 1'b1;
                  d_done <= svc_data;
               end else if (mem.mem_req) cnt <= cnt + 8'd1;
               else mem.mem_req <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               err <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: randomized bench; a behavioural model fills scoreboard queues that a
// monitor drains against the memory bus and the completion pulses.
module tb_mem_access_sequencer;
   localparam int T = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0, rst = 1'b1;
   logic        if_req = 0, d_read = 0, d_write = 0, d_unsigned = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [1:0]  d_size = 0;
   logic [31:0] if_rdata, d_rdata;
   logic        if_valid, d_done, stall;
   logic [1:0]  err;
   logic        late_ack = 1'b0;
   mem_access_sequencer_if mif();
   mem_access_sequencer #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_unsigned(d_unsigned), .d_rdata(d_rdata), .d_done(d_done), .stall(stall), .err(err), .mem(mif)
   );
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;
   typedef struct { logic dd; logic iv; logic [31:0] dr; logic [31:0] ir; logic [1:0] err; int lat; int req_cyc; } res_t;
   bus_t bus_q[$];
   res_t res_q[$];
   int   dly_q[$];
   logic [31:0] rmem[int];
   logic [31:0] mmem[int];
   logic [31:0] exp_dr = 32'h0, exp_ir = NOP;
   int checks = 0, failures = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask
   function automatic logic [31:0] init_word(input int w);
      return (32'(w) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction
   function automatic logic [31:0] rword(input int w);
      return rmem.exists(w) ? rmem[w] : init_word(w);
   endfunction
   function automatic logic [31:0] mword(input int w);
      return mmem.exists(w) ? mmem[w] : init_word(w);
   endfunction
   function automatic int pick_dly();
      return $urandom_range(0, 9) < 8 ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
   endfunction
   task automatic preload(input int w, input logic [31:0] v);
      rmem[w] = v;
      mmem[w] = v;
   endtask

   // memory responder: acks after the delay queued for each new request
   initial begin
      int wl, w;
      bit active;
      active = 0;
      wl = -1;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;
      forever begin
         @(negedge clk);
         mif.mem_ack = late_ack;
         if (rst || !mif.mem_req) active = 0;
         else begin
            if (!active) begin
               active = 1;
               wl = dly_q.size() > 0 ? dly_q.pop_front() : 0;
            end
            if (wl == 0) begin
               w = int'(mif.mem_addr >> 2);
               mif.mem_ack = 1'b1;
               mif.mem_rdata = rword(w);
               if (mif.mem_we) begin
                  logic [31:0] nw;
                  nw = rword(w);
                  for (int i = 0; i < 4; i++) if (mif.mem_be[i]) nw[8*i +: 8] = mif.mem_wdata[8*i +: 8];
                  rmem[w] = nw;
               end
               wl = -1;
            end else if (wl > 0) wl--;
         end
      end
   end

   // monitor: checks each new bus request and each completion against the queues
   initial begin
      logic prev;
      bus_t b;
      res_t r;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
            continue;
         end
         if (mif.mem_req && !prev) begin
            if (bus_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_req: got mem_req at %h, expected no request", mif.mem_addr);
            end else begin
               b = bus_q.pop_front();
               chk("mem_addr", mif.mem_addr, b.addr);
               chk("mem_we", 32'(mif.mem_we), 32'(b.we));
               chk("mem_be", 32'(mif.mem_be), 32'(b.be));
               if (b.we) chk("mem_wdata", mif.mem_wdata, b.wdata);
            end
         end
         prev = mif.mem_req;
         if (d_done || if_valid) begin
            if (res_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got d_done=%b if_valid=%b, expected none", d_done, if_valid);
            end else begin
               r = res_q.pop_front();
               chk("d_done", 32'(d_done), 32'(r.dd));
               chk("if_valid", 32'(if_valid), 32'(r.iv));
               chk("d_rdata", d_rdata, r.dr);
               chk("if_rdata", if_rdata, r.ir);
               chk("err", 32'(err), 32'(r.err));
               chk("stall_done", 32'(stall), 32'h0);
               chk("latency", 32'(cyc - r.req_cyc), 32'(r.lat));
            end
         end
      end
   end

   task automatic do_txn(input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] wd,
                         input logic [1:0] sz, input logic un, input logic ir, input logic [31:0] ia,
                         input int dd, input int fd);
      int nb, wa, dlen, flen, lat, stall_n, k;
      logic dreq, mis, ok;
      logic [3:0] be;
      logic [31:0] rep, wrd, v;
      res_t r;
      dreq = dr | dw;
      nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      mis = dreq && (da % nb != 0);
      ok = dreq && !mis;
      r.err = 2'b00;
      if (mis) begin
         r.err[0] = 1'b1;
         exp_dr = 32'h0;
      end else if (dreq) begin
         be = 4'((1 << nb) - 1) << (da % 4);
         for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % nb) +: 8];
         bus_q.push_back('{da & ~32'h3, dw, be, rep});
         dly_q.push_back(dd);
         wa = int'(da >> 2);
         if (dd >= T) r.err[1] = 1'b1;
         if (dw) begin
            if (dd < T) begin
               wrd = mword(wa);
               for (int i = 0; i < 4; i++) if (be[i]) wrd[8*i +: 8] = rep[8*i +: 8];
               mmem[wa] = wrd;
            end
         end else if (dd >= T) exp_dr = 32'h0;
         else begin
            v = mword(wa) >> (8 * (da % 4));
            if (nb == 1) v = (!un && v[7]) ? (v | 32'hFFFF_FF00) : (v & 32'hFF);
            else if (nb == 2) v = (!un && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'hFFFF);
            exp_dr = v;
         end
      end
      if (ir) begin
         bus_q.push_back('{ia & ~32'h3, 1'b0, 4'hf, 32'h0});
         dly_q.push_back(fd);
         if (fd >= T) r.err[1] = 1'b1;
         exp_ir = fd >= T ? NOP : mword(int'(ia >> 2));
      end
      dlen = ok ? (dd + 1 < T ? dd + 1 : T) : 0;
      flen = ir ? (ok ? 1 : 0) + (fd + 1 < T ? fd + 1 : T) : 0;
      lat = 1 + dlen + flen;
      r.dd = dreq;
      r.iv = ir;
      r.dr = exp_dr;
      r.ir = exp_ir;
      r.lat = lat;
      @(negedge clk);
      d_read = dr; d_write = dw; d_addr = da; d_wdata = wd; d_size = sz; d_unsigned = un;
      if_req = ir; if_addr = ia;
      r.req_cyc = cyc;
      if (dreq || ir) res_q.push_back(r);
      #1 chk("stall_req", 32'(stall), 32'(dreq | ir));
      stall_n = int'(stall);
      @(negedge clk);
      d_read = 0; d_write = 0; if_req = 0;
      d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom;
      if (dreq || ir) begin
         k = 0;
         while (!(d_done || if_valid) && k < 100) begin
            stall_n += int'(stall);
            @(negedge clk);
            k++;
         end
         if (k == 100) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no completion in 100 cycles, expected one after %0d", lat);
         end
         chk("stall_cycles", 32'(stall_n), 32'(lat));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   initial begin
      logic dr, dw, ir, un;
      logic [31:0] da, ia;
      logic [1:0] sz;
      int sel;
      repeat (2) @(negedge clk);
      chk("rst_if_rdata", if_rdata, NOP);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_mem_req", 32'(mif.mem_req), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_pulses", 32'({d_done, if_valid}), 32'h0);
      rst = 1'b0;
      // fetch with ack in third request cycle
      preload(16, 32'h0050_0093);
      do_txn(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 2);
      chk("t1_if_rdata", if_rdata, 32'h0050_0093);
      // signed byte load plus fetch in the same cycle
      preload(64, 32'h80AB_CDEF);
      do_txn(1, 0, 32'h103, 0, 2'd0, 0, 1, 32'h200, 0, 0);
      chk("t2_d_rdata", d_rdata, 32'hFFFF_FF80);
      do_txn(0, 1, 32'h22, 32'h0000_BEEF, 2'd1, 0, 0, 0, 0, 0);
      do_txn(1, 0, 32'h06, 0, 2'd2, 0, 0, 0, 0, 0);
      chk("t4_err", 32'(err), 32'h1);
      chk("t4_d_rdata", d_rdata, 32'h0);
      do_txn(0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 10);
      chk("t5_err", 32'(err), 32'h2);
      chk("t5_if_rdata", if_rdata, NOP);
      repeat (300) begin
         sel = $urandom_range(0, 5);
         dr = sel == 1 || sel == 2 || sel == 5;
         dw = sel == 3 || sel == 4 || sel == 5;
         ir = $urandom_range(0, 2) != 0;
         sz = 2'($urandom_range(0, 3));
         un = 1'($urandom_range(0, 1));
         da = $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0) da = da & ~32'(sz == 2'd0 ? 0 : sz == 2'd1 ? 1 : 3);
         ia = $urandom_range(0, 63);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_txn(dr, dw, da, $urandom, sz, un, ir, ia, pick_dly(), pick_dly());
      end
      // reset while a load is waiting on the memory
      @(negedge clk);
      bus_q.push_back('{32'h30, 1'b0, 4'hf, 32'h0});
      dly_q.push_back(50);
      d_read = 1; d_addr = 32'h30; d_size = 2'd2; if_req = 0;
      @(negedge clk);
      d_read = 0;
      chk("t6_req_before", 32'(mif.mem_req), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t6_mem_req", 32'(mif.mem_req), 32'h0);
      chk("t6_stall", 32'(stall), 32'h0);
      chk("t6_if_rdata", if_rdata, NOP);
      chk("t6_d_rdata", d_rdata, 32'h0);
      chk("t6_outs", 32'({err, d_done, if_valid, mif.mem_we, mif.mem_be}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #2 late_ack = 1'b1;
      @(negedge clk);
      #2 late_ack = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t6_idle", 32'({mif.mem_req, d_done, if_valid, stall}), 32'h0);
      end
      chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
      chk("res_q_empty", 32'(res_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
